// File: rtl/memory_access_controller.sv
// Data-memory access controller: load/store, single-word and double-word stack ops.
// Optional stack bound checking is enabled by defining STACK_BOUNDS_CHECK_EN.
module memory_access_controller #(
    parameter logic [31:0] SP_RESET   = 32'h0000_07FF,
    parameter logic [31:0] STACK_BASE = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [15:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] sp,
    output logic        stack_fault
);

    // Handshake: a request is taken when req_valid=1 and stall=0; while stall=1
    // the requester holds req_*, but WORD2 completes from latched state regardless.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WORD2 = 1'b1
    } state_t;

    localparam logic [2:0] OP_LOAD   = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_PUSH   = 3'b011;
    localparam logic [2:0] OP_POP    = 3'b100;
    localparam logic [2:0] OP_PUSH32 = 3'b101;
    localparam logic [2:0] OP_POP32  = 3'b110;

    state_t      state_q;
    logic [31:0] sp_q;
    logic        pop32_q;
    logic [15:0] hold_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        fault_q;

    logic [2:0]  op_d;
    logic [31:0] sp_m1, sp_m2, sp_p1, sp_p2;
    logic        viol_d;

    assign op_d  = req_valid ? req_op : 3'b000;
    assign sp_m1 = sp_q - 32'd1;
    assign sp_m2 = sp_q - 32'd2;
    assign sp_p1 = sp_q + 32'd1;
    assign sp_p2 = sp_q + 32'd2;

`ifdef STACK_BOUNDS_CHECK_EN
    // 33-bit compares so an sp near 0 or 2^32-1 is judged without wrap.
    always_comb begin
        viol_d = 1'b0;
        case (op_d)
            OP_PUSH:   viol_d = {1'b0, sp_q} < ({1'b0, STACK_BASE} + 33'd1);
            OP_PUSH32: viol_d = {1'b0, sp_q} < ({1'b0, STACK_BASE} + 33'd2);
            OP_POP:    viol_d = ({1'b0, sp_q} + 33'd1) > {1'b0, SP_RESET};
            OP_POP32:  viol_d = ({1'b0, sp_q} + 33'd2) > {1'b0, SP_RESET};
            default:   viol_d = 1'b0;
        endcase
    end
`else
    logic unused_stack_base;
    assign unused_stack_base = ^STACK_BASE;
    assign viol_d = 1'b0;
`endif

    always_comb begin
        mem_addr  = 32'h0;
        mem_wdata = 16'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        stall     = 1'b0;
        if (!rst_n) begin
            stall = 1'b0;
        end else if (state_q == S_WORD2) begin
            if (pop32_q) begin
                mem_read = 1'b1;
                mem_addr = sp_p2;
            end else begin
                mem_write = 1'b1;
                mem_addr  = sp_m1;
                mem_wdata = hold_q;
            end
        end else if (!viol_d) begin
            case (op_d)
                OP_LOAD: begin
                    mem_read = 1'b1;
                    mem_addr = {16'h0, req_addr};
                end
                OP_STORE: begin
                    mem_write = 1'b1;
                    mem_addr  = {16'h0, req_addr};
                    mem_wdata = req_wdata[15:0];
                end
                OP_PUSH: begin
                    mem_write = 1'b1;
                    mem_addr  = sp_q;
                    mem_wdata = req_wdata[15:0];
                end
                OP_POP: begin
                    mem_read = 1'b1;
                    mem_addr = sp_p1;
                end
                OP_PUSH32: begin
                    mem_write = 1'b1;
                    mem_addr  = sp_q;
                    mem_wdata = req_wdata[31:16];
                    stall     = 1'b1;
                end
                OP_POP32: begin
                    mem_read = 1'b1;
                    mem_addr = sp_p1;
                    stall    = 1'b1;
                end
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sp_q         <= SP_RESET;
            pop32_q      <= 1'b0;
            hold_q       <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (viol_d) begin
                        fault_q <= 1'b1;
                    end else begin
                        case (op_d)
                            OP_LOAD: begin
                                resp_valid_q <= 1'b1;
                                resp_rdata_q <= {16'h0, mem_rdata};
                            end
                            OP_PUSH: sp_q <= sp_m1;
                            OP_POP: begin
                                resp_valid_q <= 1'b1;
                                resp_rdata_q <= {16'h0, mem_rdata};
                                sp_q         <= sp_p1;
                            end
                            OP_PUSH32: begin
                                hold_q  <= req_wdata[15:0];
                                pop32_q <= 1'b0;
                                state_q <= S_WORD2;
                            end
                            OP_POP32: begin
                                hold_q  <= mem_rdata;
                                pop32_q <= 1'b1;
                                state_q <= S_WORD2;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_WORD2: begin
                    state_q <= S_IDLE;
                    if (pop32_q) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= {mem_rdata, hold_q};
                        sp_q         <= sp_p2;
                    end else begin
                        sp_q <= sp_m2;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign sp          = sp_q;
    assign stack_fault = fault_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: transaction-level stack/memory model,
// per-cycle expectation queue, directed scenarios and random traffic.
module tb_memory_access_controller;

    localparam logic [31:0] SP_RST = 32'h0000_07FF;
    localparam logic [31:0] BASE   = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [15:0] req_addr = 16'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [15:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read, mem_write, stall, resp_valid, stack_fault;
    logic [31:0] resp_rdata, sp;

    always #5 clk = ~clk;

    memory_access_controller #(.SP_RESET(SP_RST), .STACK_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .stall(stall), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .sp(sp), .stack_fault(stack_fault)
    );

    // Data memory seen by the DUT, and the model's own copy of what it should hold.
    logic [15:0] env_mem [0:65535];
    logic [15:0] ref_mem [0:65535];

    function automatic logic [15:0] dflt(input int unsigned a);
        logic [31:0] t;
        t = a * 32'h9E37;
        return t[15:0] ^ 16'hA55A;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] <= dflt(i);
            ref_mem[i] = dflt(i);
        end
    end

    assign mem_rdata = env_mem[mem_addr[15:0]];
    always @(posedge clk) if (mem_write) env_mem[mem_addr[15:0]] <= mem_wdata;

    typedef struct {
        logic        stall, rd, wr, rv, fault, chk_rdata;
        logic [31:0] addr, sp, rdata;
        logic [15:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_sp = SP_RST;
    logic        m_rv = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("stall", {31'h0, stall}, {31'h0, e.stall});
            check("mem_read", {31'h0, mem_read}, {31'h0, e.rd});
            check("mem_write", {31'h0, mem_write}, {31'h0, e.wr});
            check("sp", sp, e.sp);
            check("resp_valid", {31'h0, resp_valid}, {31'h0, e.rv});
            check("stack_fault", {31'h0, stack_fault}, {31'h0, e.fault});
            if (e.rd || e.wr) check("mem_addr", mem_addr, e.addr);
            if (e.wr) check("mem_wdata", {16'h0, mem_wdata}, {16'h0, e.wdata});
            if (e.rv || e.chk_rdata) check("resp_rdata", resp_rdata, e.rdata);
        end
    end

    // Fresh expectation for one cycle: registered outputs carry what the model
    // predicted from the previous cycle.
    task automatic new_exp(output exp_t e);
        e.stall = 1'b0; e.rd = 1'b0; e.wr = 1'b0; e.chk_rdata = 1'b0;
        e.addr = 32'h0; e.wdata = 16'h0; e.sp = m_sp;
        e.rv = m_rv; e.rdata = m_rdata; e.fault = m_fault;
        m_rv = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic apply(input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [31:0] wd, input exp_t e);
        @(posedge clk);
        #1;
        req_valid = v; req_op = op; req_addr = a; req_wdata = wd;
        exp_q.push_back(e);
    endtask

    function automatic logic stack_viol(input logic [2:0] k, input logic [31:0] s);
        longint s64, base64, top64, nxt;
        s64 = longint'({32'h0, s});
        base64 = longint'({32'h0, BASE});
        top64 = longint'({32'h0, SP_RST});
        nxt = (k == 3'd3) ? s64 - 1 : (k == 3'd5) ? s64 - 2 :
              (k == 3'd4) ? s64 + 1 : (k == 3'd6) ? s64 + 2 : s64;
`ifdef STACK_BOUNDS_CHECK_EN
        return (nxt < base64) || (nxt > top64);
`else
        return (nxt < base64) && (nxt > top64);
`endif
    endfunction

    task automatic reset_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b000;
        e.stall = 1'b0; e.rd = 1'b0; e.wr = 1'b0; e.rv = 1'b0; e.fault = 1'b0;
        e.chk_rdata = 1'b1; e.addr = 32'h0; e.wdata = 16'h0; e.sp = SP_RST; e.rdata = 32'h0;
        exp_q.push_back(e);
        m_sp = SP_RST; m_rv = 1'b0; m_fault = 1'b0; m_rdata = 32'h0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One request; two-word ops get a second cycle with scrambled inputs,
    // or a reset in that cycle when abort_w2 is set.
    task automatic do_op(input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [31:0] wd, input logic abort_w2);
        exp_t e, e2;
        logic [2:0]  k;
        logic [31:0] s, t1, t2;
        logic        viol;
        k = v ? op : 3'd0;
        s = m_sp; t1 = s + 32'd1; t2 = s + 32'd2;
        viol = stack_viol(k, s);
        new_exp(e);
        if (viol) begin
            m_fault = 1'b1;
        end else begin
            case (k)
                3'd1: begin e.rd = 1'b1; e.addr = {16'h0, a}; m_rv = 1'b1; m_rdata = {16'h0, ref_mem[a]}; end
                3'd2: begin e.wr = 1'b1; e.addr = {16'h0, a}; e.wdata = wd[15:0]; ref_mem[a] = wd[15:0]; end
                3'd3: begin e.wr = 1'b1; e.addr = s; e.wdata = wd[15:0]; ref_mem[s[15:0]] = wd[15:0]; m_sp = s - 32'd1; end
                3'd4: begin e.rd = 1'b1; e.addr = t1; m_rv = 1'b1; m_rdata = {16'h0, ref_mem[t1[15:0]]}; m_sp = t1; end
                3'd5: begin e.stall = 1'b1; e.wr = 1'b1; e.addr = s; e.wdata = wd[31:16]; ref_mem[s[15:0]] = wd[31:16]; end
                3'd6: begin e.stall = 1'b1; e.rd = 1'b1; e.addr = t1; end
                default: e.stall = 1'b0;
            endcase
        end
        apply(v, op, a, wd, e);
        if (!viol && (k == 3'd5 || k == 3'd6)) begin
            if (abort_w2) begin
                reset_cycle();
            end else begin
                new_exp(e2);
                if (k == 3'd5) begin
                    t1 = s - 32'd1;
                    e2.wr = 1'b1; e2.addr = t1; e2.wdata = wd[15:0];
                    ref_mem[t1[15:0]] = wd[15:0];
                    m_sp = s - 32'd2;
                end else begin
                    e2.rd = 1'b1; e2.addr = t2;
                    m_rv = 1'b1;
                    m_rdata = {ref_mem[t2[15:0]], ref_mem[t1[15:0]]};
                    m_sp = t2;
                end
                apply(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      16'($urandom), $urandom, e2);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        reset_cycle();

        do_op(1'b1, 3'd3, 16'h0, 32'h0000_ABCD, 1'b0);
        check("pin sp after push", m_sp, 32'h0000_07FE);
        do_op(1'b1, 3'd4, 16'h0, 32'h0, 1'b0);
        check("mem[7FF] after push", {16'h0, env_mem[16'h07FF]}, 32'h0000_ABCD);
        check("pin pop data", m_rdata, 32'h0000_ABCD);
        check("pin sp after pop", m_sp, 32'h0000_07FF);

        do_op(1'b1, 3'd5, 16'h0, 32'h1234_5678, 1'b0);
        do_op(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);
        check("mem[7FF] push32 hi", {16'h0, env_mem[16'h07FF]}, 32'h0000_1234);
        check("mem[7FE] push32 lo", {16'h0, env_mem[16'h07FE]}, 32'h0000_5678);
        check("pin sp after push32", m_sp, 32'h0000_07FD);
        do_op(1'b1, 3'd6, 16'h0, 32'h0, 1'b0);
        check("pin pop32 data", m_rdata, 32'h1234_5678);
        check("pin sp after pop32", m_sp, 32'h0000_07FF);

        do_op(1'b1, 3'd2, 16'h0010, 32'h0000_00FF, 1'b0);
        do_op(1'b1, 3'd1, 16'h0010, 32'h0, 1'b0);
        check("pin load data", m_rdata, 32'h0000_00FF);

        do_op(1'b1, 3'd4, 16'h0, 32'h0, 1'b0);
`ifdef STACK_BOUNDS_CHECK_EN
        check("pin sp pop at top", m_sp, 32'h0000_07FF);
        check("pin fault pop at top", {31'h0, m_fault}, 32'h1);
`else
        check("pin sp pop at top", m_sp, 32'h0000_0800);
        check("pin fault pop at top", {31'h0, m_fault}, 32'h0);
`endif
        do_op(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            do_op(1'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                  16'($urandom_range(0, 63)), $urandom, 1'b0);
        end

        reset_cycle();
        do_op(1'b1, 3'd5, 16'h0, 32'hDEAD_BEEF, 1'b1);
        check("pin sp after abort", m_sp, 32'h0000_07FF);
        do_op(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);
        check("abort keeps hi word", {16'h0, env_mem[16'h07FF]}, 32'h0000_DEAD);
        check("abort skips lo word", {16'h0, env_mem[16'h07FE]}, {16'h0, ref_mem[16'h07FE]});

        do_op(1'b1, 3'd5, 16'h0, 32'hCAFE_F00D, 1'b0);
        do_op(1'b1, 3'd6, 16'h0, 32'h0, 1'b0);
        do_op(1'b1, 3'd3, 16'h0, 32'h0000_1111, 1'b0);
        do_op(1'b1, 3'd4, 16'h0, 32'h0, 1'b0);
        do_op(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);
        do_op(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        check("expectations drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
